mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  fetch request; held with if_addr until if_gnt.
REQ-005 SHALL have port if_addr  input  32  fetch word address.
REQ-006 SHALL have port if_gnt  output  1  one-cycle pulse; fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-008 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-009 SHALL have port d_req  input  1  data request; held with d_we, d_addr and d_wdata until d_gnt.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_addr  input  32  data address.
REQ-012 SHALL have port d_wdata  input  32  store data.
REQ-013 SHALL have port d_gnt  output  1  one-cycle pulse; data request accepted.
REQ-014 SHALL have port d_rvalid  output  1  one-cycle pulse; load data valid or store complete.
REQ-015 SHALL have port d_rdata  output  32  load data.
REQ-016 SHALL have port m_req  output  1  memory request; held until m_ack.
REQ-017 SHALL have ports m_we, m_addr and m_wdata  output  1/32/32  latched command to memory.
REQ-018 SHALL have port m_ack  input  1  memory completion; m_rdata valid in the same cycle.
REQ-019 SHALL have port m_rdata  input  32  memory read data.

Function
REQ-020 SHALL implement the FSM states IDLE, BUSY_I and BUSY_D.
REQ-021 In IDLE, SHALL grant data (d_gnt=1, move to BUSY_D) when d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX).
REQ-022 Otherwise in IDLE, SHALL grant fetch (if_gnt=1, move to BUSY_I) when if_req=1; with no request, stays in IDLE.
REQ-023 Grants SHALL be combinational from state and requests, and SHALL be asserted only in IDLE; at most one grant per cycle.
REQ-024 On a grant, SHALL register the address, we (0 for fetch) and wdata (0 for fetch) into m_addr, m_we and m_wdata; later changes to requester inputs SHALL be ignored.
REQ-025 In BUSY_x, SHALL hold m_req=1 and the command stable until m_ack=1 is sampled; m_req SHALL be 0 in IDLE.
REQ-026 On m_ack in BUSY_x, SHALL register m_rdata into the owner's rdata, pulse the owner's rvalid in the next cycle and return to IDLE in that same next cycle.
REQ-027 On store completion, SHALL pulse d_rvalid and leave d_rdata unchanged.
REQ-028 Minimum latency: grant at cycle N, m_req at N+1, m_ack at N+1 gives rvalid at N+2, when a new grant is also possible.
REQ-029 m_ack while in IDLE SHALL be ignored.
REQ-030 starve_cnt SHALL increment on each data grant while if_req=1, saturate at STARVE_MAX, and clear on every fetch grant or whenever if_req=0 in IDLE.

Reset
REQ-031 Asserting rst SHALL, at any time including mid-transaction, force IDLE, starve_cnt=0 and all outputs (grants, rvalids, rdata, m_*) to 0; an abandoned transaction SHALL produce no rvalid.
REQ-032 After rst deasserts, the first grant SHALL be possible on the first rising edge.

Structure
REQ-033 The arb_state_t enum (IDLE, BUSY_I, BUSY_D) and the STARVE_MAX default SHALL live in the shared core package.
REQ-034 The design SHALL be a single module with no sub-module; the starvation counter is inline.

Verification
REQ-035 The bench SHALL drive a lone fetch if_addr=0x10 with m_ack the cycle after m_req, and check if_gnt at N, m_addr=0x10 and m_we=0 at N+1, and if_rvalid at N+2 with m_rdata passed through.
REQ-036 The bench SHALL drive a store d_addr=0x40, d_wdata=0xDEADBEEF with m_ack delayed 3 cycles, and check m_req high for 4 cycles, the command stable throughout, a single d_rvalid and d_rdata unchanged.
REQ-037 The bench SHALL hold if_req and d_req both high continuously with STARVE_MAX=4, and check the grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 The bench SHALL assert rst during BUSY_D before m_ack, and check outputs zero immediately, no d_rvalid, and a clean grant after release.
REQ-039 The bench SHALL pulse m_ack while in IDLE, and check no rvalid and no state change.
REQ-040 The bench SHALL change d_addr from 0x40 to 0x80 the cycle after d_gnt, and check that m_addr stays 0x40.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding and
// the default bound on data grants issued while a fetch is waiting.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;

  // Counter width able to hold 0..max inclusive.
  function automatic int starve_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, data) arbiter onto a single-outstanding memory port.
// Data wins by default; a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int              CW    = starve_w(STARVE_MAX);
  localparam logic [CW-1:0]   S_MAX = CW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          m_we_q, m_we_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          d_pick;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    d_pick      = d_req && (!if_req || (starve_q < S_MAX));

    case (state_q)
      IDLE: begin
        // Grants are gated by rst so outputs read zero throughout reset.
        if (!rst) begin
          if (d_pick) begin
            d_gnt     = 1'b1;
            state_d   = BUSY_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end else if (if_req) begin
            if_gnt    = 1'b1;
            state_d   = BUSY_I;
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = 32'd0;
          end
          if (!if_req || if_gnt)
            starve_d = '0;
          else if (d_gnt && (starve_q != S_MAX))
            starve_d = starve_q + 1'b1;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          if_rdata_d  = m_rdata;
          if_rvalid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          // Stores complete without disturbing the last load result.
          if (!m_we_q) d_rdata_d = m_rdata;
          d_rvalid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      m_we_q      <= 1'b0;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  assign m_req     = (state_q != IDLE);
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_rvalid  = d_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ignt"}, if_gnt, 0);    chk({tag, "_dgnt"}, d_gnt, 0);
    chk({tag, "_irv"}, if_rvalid, 0);  chk({tag, "_drv"}, d_rvalid, 0);
    chk({tag, "_ird"}, if_rdata, 0);   chk({tag, "_drd"}, d_rdata, 0);
    chk({tag, "_mreq"}, m_req, 0);     chk({tag, "_mwe"}, m_we, 0);
    chk({tag, "_maddr"}, m_addr, 0);   chk({tag, "_mwd"}, m_wdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_ir, exp_dr, ack_data, c_addr, c_wd;
    logic        c_we;
    bit          busy, own_d, ack_prev, eg_d, eg_i;
    int          streak, ngr, cnt;
    byte         seq[10];
    byte         exp_seq;

    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; m_ack = 0; m_rdata = 0;
    exp_ir = 0; exp_dr = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Lone fetch, ack right after m_req.
    if_req = 1; if_addr = 32'h10;
    #1;
    chk("f_ignt", if_gnt, 1); chk("f_dgnt", d_gnt, 0); chk("f_mreq0", m_req, 0);
    tick();
    if_req = 0; if_addr = 32'hFFFF_0000;
    chk("f_mreq", m_req, 1); chk("f_maddr", m_addr, 32'h10); chk("f_mwe", m_we, 0);
    chk("f_mwd", m_wdata, 0); chk("f_ignt_busy", if_gnt, 0);
    rd = $urandom; m_ack = 1; m_rdata = rd;
    tick();
    m_ack = 0;
    exp_ir = rd;
    chk("f_irv", if_rvalid, 1); chk("f_ird", if_rdata, exp_ir);
    chk("f_drv", d_rvalid, 0); chk("f_mreq_done", m_req, 0);
    tick();
    chk("f_irv_pulse", if_rvalid, 0);

    // Load to give d_rdata a known non-zero value.
    d_req = 1; d_we = 0; d_addr = 32'h20;
    #1; chk("ld_dgnt", d_gnt, 1);
    tick();
    d_req = 0;
    rd = $urandom | 32'h1; m_ack = 1; m_rdata = rd;
    tick();
    m_ack = 0; exp_dr = rd;
    chk("ld_drv", d_rvalid, 1); chk("ld_drd", d_rdata, exp_dr);
    tick();

    // Store with ack delayed 3 cycles; requester address changes after grant.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    #1; chk("st_dgnt", d_gnt, 1);
    tick();
    d_req = 0; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_we = 0;
    for (int k = 0; k < 4; k++) begin
      chk("st_mreq", m_req, 1); chk("st_maddr", m_addr, 32'h40);
      chk("st_mwe", m_we, 1); chk("st_mwd", m_wdata, 32'hDEADBEEF);
      chk("st_drv_early", d_rvalid, 0);
      if (k == 3) begin m_ack = 1; m_rdata = 32'hCAFE_F00D; end
      tick();
    end
    m_ack = 0;
    chk("st_drv", d_rvalid, 1); chk("st_drd", d_rdata, exp_dr);
    chk("st_mreq_done", m_req, 0);
    tick();
    chk("st_drv_pulse", d_rvalid, 0);

    // m_ack in IDLE is ignored.
    m_ack = 1; m_rdata = 32'h5555_AAAA;
    tick();
    m_ack = 0;
    chk("ia_irv", if_rvalid, 0); chk("ia_drv", d_rvalid, 0);
    chk("ia_mreq", m_req, 0); chk("ia_ird", if_rdata, exp_ir); chk("ia_drd", d_rdata, exp_dr);
    tick();
    chk("ia_irv2", if_rvalid, 0); chk("ia_drv2", d_rvalid, 0);
    if_req = 1; if_addr = 32'h44;
    #1; chk("ia_still_idle", if_gnt, 1);
    tick();
    if_req = 0; m_ack = 1; m_rdata = $urandom; exp_ir = m_rdata;
    tick();
    m_ack = 0;
    chk("ia_f_irv", if_rvalid, 1); chk("ia_f_ird", if_rdata, exp_ir);
    tick();

    // Both requesters held high: model the rotation from the starvation rule.
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
    ngr = 0; cnt = 0;
    while (ngr < 10 && cnt < 60) begin
      m_ack = m_req; m_rdata = $urandom;
      #1;
      if (d_gnt && if_gnt) chk("sv_one_gnt", 1, 0);
      if (d_gnt) begin seq[ngr] = "D"; ngr++; end
      else if (if_gnt) begin seq[ngr] = "I"; ngr++; end
      tick();
      cnt++;
    end
    chk("sv_gcount", ngr, 10);
    if_req = 0; d_req = 0;
    repeat (4) begin m_ack = m_req; tick(); end
    m_ack = 0;
    streak = 0;
    for (int i = 0; i < ngr; i++) begin
      if (streak < SM) begin exp_seq = "D"; streak++; end
      else begin exp_seq = "I"; streak = 0; end
      chk($sformatf("sv_order%0d", i), seq[i], exp_seq);
    end
    exp_ir = if_rdata; exp_dr = d_rdata;
    tick();

    // Reset in BUSY_D before m_ack.
    d_req = 1; d_we = 0; d_addr = 32'h300;
    #1; chk("rb_dgnt", d_gnt, 1);
    tick();
    d_req = 0;
    chk("rb_busy", m_req, 1);
    rst = 1; if_req = 1; if_addr = 32'h88;
    #1;
    chk_all_zero("rb");
    m_ack = 1; m_rdata = 32'h7777_7777;
    tick();
    chk_all_zero("rb_hold");
    rst = 0; m_ack = 0;
    #1;
    chk("rb_ignt", if_gnt, 1); chk("rb_drv0", d_rvalid, 0);
    tick();
    if_req = 0;
    chk("rb_maddr", m_addr, 32'h88); chk("rb_drv1", d_rvalid, 0);
    m_ack = 1; m_rdata = $urandom; exp_ir = m_rdata; exp_dr = 0;
    tick();
    m_ack = 0;
    chk("rb_irv", if_rvalid, 1); chk("rb_ird", if_rdata, exp_ir); chk("rb_drv2", d_rvalid, 0);
    tick();

    // Randomized traffic against the transaction-level model.
    busy = 0; own_d = 0; ack_prev = 0; streak = 0;
    c_addr = 0; c_wd = 0; c_we = 0; ack_data = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      m_ack = 0;
      if (ack_prev) begin
        chk("rn_irv", if_rvalid, !own_d); chk("rn_drv", d_rvalid, own_d);
        if (!own_d) exp_ir = ack_data;
        else if (!c_we) exp_dr = ack_data;
        busy = 0; ack_prev = 0;
      end else begin
        chk("rn_irv0", if_rvalid, 0); chk("rn_drv0", d_rvalid, 0);
      end
      chk("rn_ird", if_rdata, exp_ir); chk("rn_drd", d_rdata, exp_dr);
      chk("rn_mreq", m_req, busy);
      if (busy) begin
        chk("rn_maddr", m_addr, c_addr); chk("rn_mwe", m_we, c_we); chk("rn_mwd", m_wdata, c_wd);
        if ($urandom_range(2) == 0) begin
          m_ack = 1; m_rdata = $urandom; ack_data = m_rdata; ack_prev = 1;
        end
      end else if ($urandom_range(3) == 0) begin
        m_ack = 1; m_rdata = $urandom;
      end
      if (!if_req && $urandom_range(2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      #1;
      eg_d = !busy && d_req && (!if_req || streak < SM);
      eg_i = !busy && if_req && !eg_d;
      chk("rn_dgnt", d_gnt, eg_d); chk("rn_ignt", if_gnt, eg_i);
      if (!busy) begin
        if (!if_req || eg_i) streak = 0;
        else if (eg_d && streak < SM) streak++;
      end
      if (eg_d) begin
        busy = 1; own_d = 1; c_addr = d_addr; c_we = d_we; c_wd = d_wdata;
      end else if (eg_i) begin
        busy = 1; own_d = 0; c_addr = if_addr; c_we = 0; c_wd = 0;
      end
      tick();
      if (eg_d) begin d_req = 0; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); end
      if (eg_i) begin if_req = 0; if_addr = $urandom; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
